// File: rtl/arb_grant_mux.sv
// arb_grant_mux
// Takes the round-robin arbiter's registered one-hot grant and captures the
// granted requester's payload into a small first-word-fall-through FIFO.
// The FIFO entry is tagged with the source index of the requester.
// The module pulses a pop back to the accepted requester. It drives the
// arbiter's stall input while the FIFO is full, which freezes the arbiter's
// round-robin pointer.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset
//   grant      registered one-hot grant from the arbiter (NUM_REQ)
//   req_data   flattened payloads, requester i at [i*DATA_W +: DATA_W]
//   req_pop    one-cycle dequeue pulse to the accepted requester
//   stall      high while the FIFO is full (registered count only)
//   out_valid  FIFO head valid
//   out_ready  downstream accepts the head
//   out_data   head payload
//   out_src    head requester index
//   grant_err  sticky flag, set on a multi-hot grant
//   drop_cnt   saturating count of one-hot grants refused while full
module arb_grant_mux #(
  parameter  int NUM_REQ = 8,
  parameter  int DATA_W  = 64,
  parameter  int DEPTH   = 2,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        grant,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_pop,
  output logic                      stall,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic                      grant_err,
  output logic [15:0]               drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [SRC_W-1:0]  r_mem_src  [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_grant_err;
  logic [15:0]       r_drop_cnt;

  logic              w_full;
  logic              w_nonempty;
  logic              w_onehot;
  logic              w_multi;
  logic              w_push;
  logic              w_pop;
  logic              w_refuse;
  logic [SRC_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_sel_data;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_nonempty = (r_count != '0);

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign w_onehot = (grant != '0) && ((grant & (grant - NUM_REQ'(1))) == '0);
  assign w_multi  = (grant != '0) && !w_onehot;

  // Full is taken from the registered count, so a pop in the same cycle
  // does not let a push through.
  assign w_push   = w_onehot && !w_full;
  assign w_refuse = w_onehot && w_full;
  assign w_pop    = w_nonempty && out_ready;

  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) w_idx = SRC_W'(i);
    end
  end

  assign w_sel_data = req_data[w_idx*DATA_W +: DATA_W];

  assign req_pop   = w_push ? grant : '0;
  assign stall     = w_full;
  assign out_valid = w_nonempty;
  // The storage array has no reset. Gating the head while the FIFO is empty
  // keeps out_data and out_src at zero after reset.
  assign out_data  = w_nonempty ? r_mem_data[r_head] : '0;
  assign out_src   = w_nonempty ? r_mem_src[r_head]  : '0;
  assign grant_err = r_grant_err;
  assign drop_cnt  = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_tail] <= w_sel_data;
      r_mem_src[r_tail]  <= w_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_grant_err <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      if (w_multi) r_grant_err <= 1'b1;
      if (w_refuse && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_arb_grant_mux.sv
// tb_arb_grant_mux
// Testbench for arb_grant_mux. It runs the directed scenarios first, then
// random grant/ready traffic. Every check is made against a queue-based
// model of the FIFO.
module tb_arb_grant_mux;

  localparam int NUM_REQ = 8;
  localparam int DATA_W  = 64;
  localparam int DEPTH   = 2;
  localparam int SRC_W   = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_pop;
  logic                      stall;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;
  logic                      grant_err;
  logic [15:0]               drop_cnt;

  always #5 clk = ~clk;

  arb_grant_mux #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .grant(grant), .req_data(req_data),
    .req_pop(req_pop), .stall(stall), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .grant_err(grant_err), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t        m_q[$];
  int unsigned m_drop;
  bit          m_err;
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_REQ; i++)
      req_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drop = 0;
    m_err  = 1'b0;
  endtask

  // Called 1 time unit after a rising edge. It drives the inputs, checks the
  // outputs in mid-cycle, then advances the model across the next edge.
  task automatic step(input logic [NUM_REQ-1:0] g, input logic rdy);
    int   ones;
    bit   full;
    int   idx;
    ent_t e;
    grant     = g;
    out_ready = rdy;
    #3;
    ones = $countones(g);
    full = (m_q.size() == DEPTH);
    chk("req_pop", 64'(req_pop), (ones == 1 && !full) ? 64'(g) : 64'd0);
    chk("stall", 64'(stall), 64'(full));
    chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("out_data", out_data, m_q[0].data);
      chk("out_src", 64'(out_src), 64'(m_q[0].src));
    end
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("grant_err", 64'(grant_err), 64'(m_err));
    idx    = (ones == 1) ? $clog2(g) : 0;
    e.src  = SRC_W'(idx);
    e.data = req_data[idx*DATA_W +: DATA_W];
    @(posedge clk);
    #1;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (ones == 1 && !full) m_q.push_back(e);
    if (ones == 1 && full && m_drop != 32'hFFFF) m_drop++;
    if (ones > 1) m_err = 1'b1;
  endtask

  task automatic mid_reset();
    grant = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_grant_err", 64'(grant_err), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_req_pop", 64'(req_pop), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic rand_phase(input int n, input bit allow_multi);
    logic [NUM_REQ-1:0] g;
    int r;
    int a;
    int b;
    for (int k = 0; k < n; k++) begin
      rand_data();
      r = $urandom_range(0, 9);
      if (r < 2) g = '0;
      else if (r < 9 || !allow_multi) g = NUM_REQ'(1) << $urandom_range(0, NUM_REQ - 1);
      else begin
        a = $urandom_range(0, NUM_REQ - 1);
        b = (a + $urandom_range(1, NUM_REQ - 1)) % NUM_REQ;
        g = (NUM_REQ'(1) << a) | (NUM_REQ'(1) << b);
      end
      step(g, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    reset     = 1'b0;
    grant     = '0;
    out_ready = 1'b0;
    req_data  = '0;
    model_reset();
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_src", 64'(out_src), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single grant.
    rand_data();
    req_data[2*DATA_W +: DATA_W] = 64'hA5;
    step(8'h04, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);

    // Fill, then refuse, then drain.
    rand_data(); step(8'h01, 1'b0);
    rand_data(); step(8'h02, 1'b0);
    rand_data(); step(8'h04, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1);

    // Back-to-back streaming.
    for (int i = 0; i < NUM_REQ; i++) begin
      rand_data();
      step(NUM_REQ'(1) << i, 1'b1);
    end
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);

    // Full with a simultaneous pop, then the re-grant.
    rand_data(); step(8'h01, 1'b0);
    rand_data(); step(8'h02, 1'b0);
    rand_data(); step(8'h10, 1'b1);
    step(8'h10, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1);

    // Multi-hot grant, then valid traffic.
    rand_data(); step(8'h06, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step(NUM_REQ'(1) << i, 1'b1);
    end

    // Reset while the FIFO holds two entries.
    rand_data(); step(8'h20, 1'b0);
    rand_data(); step(8'h40, 1'b0);
    mid_reset();
    rand_data(); step(8'h08, 1'b1);
    step(8'h00, 1'b1);

    rand_phase(300, 1'b0);
    mid_reset();
    rand_phase(300, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/arb_grant_mux.md
Name: arb_grant_mux

Overview:
- Downstream consumer of the round-robin arbiter's registered one-hot grant.
- Selects the granted requester's payload and captures it, with source ID, into a small first-word-fall-through output FIFO.
- Pulses a pop back to the granted requester and presents the data to the shared resource over valid/ready.
- Drives the arbiter's stall input whenever it cannot accept, which freezes the arbiter's round-robin pointer.

Parameters:
- NUM_REQ, 8, number of requesters; equals the arbiter's VECTOR_IN.
- DATA_W, 64, payload width per requester.
- DEPTH, 2, output FIFO depth; power of 2, >=2.
- SRC_W, $clog2(NUM_REQ), source-ID width; derived, not overridden.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- grant  input  NUM_REQ  registered one-hot grant from the arbiter.
- req_data  input  NUM_REQ*DATA_W  flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_pop  output  NUM_REQ  one-cycle dequeue pulse to the accepted requester.
- stall  output  1  to the arbiter's stall input; high when FIFO full.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  DATA_W  head payload.
- out_src  output  SRC_W  head requester index.
- grant_err  output  1  sticky; set on a multi-hot grant.
- drop_cnt  output  16  saturating count of grants refused while full.

Behaviour:
- Reset (async assert, sync deassert by flop nature):
  - FIFO pointers and count = 0.
  - out_valid = 0, out_data = 0, out_src = 0.
  - req_pop = 0, stall = 0, grant_err = 0, drop_cnt = 0.
  - Reset asserted mid-operation flushes all entries; no pop pulse is issued for flushed data.
- full = (count == DEPTH). stall = full, decoded from registered count only; no combinational path from grant or out_ready to stall.
- Accept condition (push): grant is exactly one-hot and !full.
  - Writes req_data slice and the encoded index into the FIFO at the tail.
  - Drives req_pop = grant combinationally in the same cycle; the requester dequeues at that edge.
- Refuse, grant nonzero and full:
  - No push, req_pop = 0, drop_cnt increments, saturating at 16'hFFFF.
  - The requester keeps its request asserted. Because stall froze the arbiter mask, it is re-granted.
- Multi-hot grant (more than one bit set):
  - No push, req_pop = 0, grant_err set; it clears only on reset.
  - Not counted in drop_cnt.
- grant == 0: no action.
- Pop condition: out_valid && out_ready. Head pointer advances.
- FWFT: out_valid = (count != 0); out_data and out_src reflect the head entry. A pushed entry becomes visible on out_* the cycle after the push edge.
- Push and pop in the same cycle:
  - Allowed whenever !full; count unchanged.
  - When full, the push is refused even if a pop occurs that cycle (full is evaluated on registered count). stall deasserts the following cycle.
- Latency: grant edge to out_valid is 1 cycle when the FIFO is empty; throughput is 1 entry/cycle with out_ready held high.
- Pointers: log2(DEPTH) bits, wrap naturally. count: log2(DEPTH)+1 bits.
- out_ready while !out_valid: ignored.

Test Plan:
- Single grant: grant=8'h04, req_data slice2=64'hA5, out_ready=1 -> req_pop=8'h04 same cycle; next cycle out_valid=1, out_data=64'hA5, out_src=2; count returns to 0.
- Fill: out_ready=0, grants 8'h01 then 8'h02 -> stall=1 after the second push. Third grant 8'h04 -> req_pop=0, drop_cnt=1. Raise out_ready -> heads out_src=0 then 1 in order, stall drops.
- Back-to-back streaming: out_ready=1, grants 8'h01,8'h02,...,8'h80 on consecutive cycles -> 8 outputs on consecutive cycles, out_src 0..7, stall never asserts, drop_cnt=0.
- Multi-hot: grant=8'h06 -> no push, req_pop=0, grant_err=1 and stays 1 through subsequent valid traffic.
- Full with simultaneous pop: FIFO full, out_ready=1, grant=8'h10 -> pop occurs, push refused, drop_cnt+1. Next cycle stall=0; the re-asserted grant 8'h10 is then accepted.
- Reset mid-stream: FIFO holding 2 entries, reset low for 1 cycle -> out_valid=0, stall=0, drop_cnt=0, grant_err=0 immediately (async); normal accept on the first grant after release.
